// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the radix-2 SDF butterfly stage controllers of the
// 16-lane, 512-point FFT pipeline.
//   bf_state_e     : input-side FSM state of a stage controller
//   STAGEn_HALF    : beats per half frame (delay-line depth) of stage n
//   STAGEn_FAC_OFS : beat offset inside the compute phase where the
//                    twiddle factor is first applied in stage n
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE
    } bf_state_e;

    localparam int STAGE0_HALF    = 16;
    localparam int STAGE0_FAC_OFS = 8;
    localparam int STAGE1_HALF    = 8;
    localparam int STAGE1_FAC_OFS = 4;
    localparam int STAGE2_HALF    = 4;
    localparam int STAGE2_FAC_OFS = 2;
    localparam int STAGE3_HALF    = 2;
    localparam int STAGE3_FAC_OFS = 1;

endpackage

// File: rtl/fft_bf_stage_ctrl.sv
// Sequencing controller for one radix-2 single-path delay-feedback butterfly
// stage. Counts the 2*HALF contiguous input beats of a frame and decodes the
// datapath control lines from registered state only.
//   clk       : clock
//   rstn      : asynchronous active-low reset
//   valid_in  : one input beat on the datapath this cycle
//   in_sel    : 0 = beat into delay line, 1 = beat into add/sub unit
//   fac_cal   : apply twiddle factor in add/sub unit
//   out_sel   : 0 = output add result, 1 = output stored sub result
//   out_valid : stage output beat valid
//   out_last  : final output beat of a frame
//   busy      : load, compute or drain in progress
//   err_gap   : one-cycle pulse, frame aborted by a valid_in gap
//   frame_cnt : completed frames, wraps modulo 2^CNT_W
module fft_bf_stage_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int HALF    = STAGE0_HALF,
    parameter int FAC_OFS = STAGE0_FAC_OFS,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    output logic             in_sel,
    output logic             fac_cal,
    output logic             out_sel,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             err_gap,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = $clog2(2 * HALF);
    localparam int DW = $clog2(HALF + 1);

    localparam logic [BW-1:0] LAST_LOAD = BW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(2 * HALF - 1);
    localparam logic [BW-1:0] FAC_BEAT  = BW'(HALF + FAC_OFS);

    bf_state_e        state_q, state_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [DW-1:0]    dcnt_q;
    logic             err_q, err_d;
    logic             frame_done;
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    // After the last beat the FSM parks in IDLE with bcnt=0: a beat present
    // in the following cycle is then accepted as beat 0 of the next frame,
    // so back-to-back frames need no special path.
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        err_d      = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    bcnt_d  = BW'(1);
                    state_d = (HALF == 1) ? COMPUTE : LOAD;
                end
            end
            LOAD: begin
                if (valid_in) begin
                    bcnt_d = bcnt_q + BW'(1);
                    if (bcnt_q == LAST_LOAD) begin
                        state_d = COMPUTE;
                    end
                end else begin
                    err_d   = 1'b1;
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                if (valid_in) begin
                    if (bcnt_q == LAST_BEAT) begin
                        frame_done = 1'b1;
                        bcnt_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end else begin
                    err_d   = 1'b1;
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                bcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Drain runs off the delay lines, which shift every clock, so it ignores
    // valid_in. A new frame cannot complete within HALF cycles of the
    // previous one, so frame_done never collides with a running drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt_q <= '0;
        end else if (frame_done) begin
            dcnt_q <= DW'(HALF);
        end else if (dcnt_q != '0) begin
            dcnt_q <= dcnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
        end else if (dcnt_q == DW'(1)) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    // In COMPUTE bcnt >= HALF, so bcnt-HALF >= FAC_OFS reduces to this compare.
    assign in_sel    = (state_q == COMPUTE);
    assign fac_cal   = (state_q == COMPUTE) && (bcnt_q >= FAC_BEAT);
    assign out_sel   = (dcnt_q != '0);
    assign out_valid = (state_q == COMPUTE) || (dcnt_q != '0);
    assign out_last  = (dcnt_q == DW'(1));
    assign busy      = (state_q != IDLE) || (dcnt_q != '0);
    assign err_gap   = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_bf_stage_ctrl.sv
// Self-checking bench for fft_bf_stage_ctrl: directed timing scenarios plus
// randomized valid_in streams, compared against a beat/drain count model.
module tb_fft_bf_stage_ctrl;
    import fft_ctrl_pkg::*;

    localparam int HALF    = 16;
    localparam int FAC_OFS = 8;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             valid_in = 1'b0;
    logic             in_sel, fac_cal, out_sel, out_valid, out_last, busy, err_gap;
    logic [CNT_W-1:0] frame_cnt;
    logic             w_in_sel, w_fac_cal, w_out_sel, w_out_valid, w_out_last, w_busy, w_err_gap;
    logic [1:0]       w_frame_cnt;

    always #5 clk = ~clk;

    fft_bf_stage_ctrl #(.HALF(HALF), .FAC_OFS(FAC_OFS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .in_sel(in_sel), .fac_cal(fac_cal), .out_sel(out_sel),
        .out_valid(out_valid), .out_last(out_last), .busy(busy),
        .err_gap(err_gap), .frame_cnt(frame_cnt)
    );

    fft_bf_stage_ctrl #(.HALF(HALF), .FAC_OFS(FAC_OFS), .CNT_W(2)) dut_w (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .in_sel(w_in_sel), .fac_cal(w_fac_cal), .out_sel(w_out_sel),
        .out_valid(w_out_valid), .out_last(w_out_last), .busy(w_busy),
        .err_gap(w_err_gap), .frame_cnt(w_frame_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: contiguous beats of the current frame, cycles of drain
    // left, frames completed, and whether an abort happened last cycle.
    int m_beats, m_drain, m_frames;
    bit m_err;

    task automatic model_reset();
        m_beats  = 0;
        m_drain  = 0;
        m_frames = 0;
        m_err    = 0;
    endtask

    task automatic model_step(input bit v);
        bit done;
        done  = 0;
        m_err = 0;
        if (v) begin
            m_beats++;
            if (m_beats == 2 * HALF) begin
                m_beats = 0;
                done    = 1;
            end
        end else if (m_beats > 0) begin
            m_err   = 1;
            m_beats = 0;
        end
        if (m_drain > 0) begin
            if (m_drain == 1) m_frames++;
            m_drain--;
        end
        if (done) m_drain = HALF;
    endtask

    task automatic check_outputs();
        bit comp;
        comp = (m_beats >= HALF);
        check_val("in_sel",    in_sel,    comp);
        check_val("fac_cal",   fac_cal,   comp && (m_beats - HALF >= FAC_OFS));
        check_val("out_sel",   out_sel,   m_drain > 0);
        check_val("out_valid", out_valid, comp || m_drain > 0);
        check_val("out_last",  out_last,  m_drain == 1);
        check_val("busy",      busy,      m_beats > 0 || m_drain > 0);
        check_val("err_gap",   err_gap,   m_err);
        check_val("frame_cnt", frame_cnt, m_frames % (1 << CNT_W));
        check_val("w_out_valid", w_out_valid, comp || m_drain > 0);
        check_val("w_frame_cnt", w_frame_cnt, m_frames % 4);
    endtask

    // Per-scenario timing trackers, indexed by cycle since scenario start.
    int cyc, first_ov, n_ov, last_ol, n_last, err_cyc, first_in, n_in, first_fac, n_fac, n_osel;

    task automatic clear_trk();
        cyc = 0; first_ov = -1; n_ov = 0; last_ol = -1; n_last = 0; err_cyc = -1;
        first_in = -1; n_in = 0; first_fac = -1; n_fac = 0; n_osel = 0;
    endtask

    task automatic cycle(input bit v);
        @(negedge clk);
        valid_in = v;
        check_outputs();
        if (out_valid === 1'b1) begin if (first_ov < 0) first_ov = cyc; n_ov++; end
        if (out_last === 1'b1) begin last_ol = cyc; n_last++; end
        if (err_gap === 1'b1) err_cyc = cyc;
        if (in_sel === 1'b1) begin if (first_in < 0) first_in = cyc; n_in++; end
        if (fac_cal === 1'b1) begin if (first_fac < 0) first_fac = cyc; n_fac++; end
        if (out_sel === 1'b1) n_osel++;
        cyc++;
        @(posedge clk);
        model_step(v);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        valid_in = 1'b0;
        check_outputs();
        #1 rstn = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        clear_trk();
    endtask

    initial begin
        model_reset();
        clear_trk();
        #12 rstn = 1'b1;

        // Single frame
        apply_reset();
        for (int c = 0; c < 56; c++) cycle(c < 32);
        check_val("sf_first_in_sel", first_in, 16);
        check_val("sf_n_in_sel", n_in, 16);
        check_val("sf_first_fac", first_fac, 24);
        check_val("sf_n_fac", n_fac, 8);
        check_val("sf_first_ov", first_ov, 16);
        check_val("sf_n_ov", n_ov, 32);
        check_val("sf_n_out_sel", n_osel, 16);
        check_val("sf_last", last_ol, 47);
        check_val("sf_frame_cnt", frame_cnt, 1);
        check_val("sf_busy_end", busy, 0);

        // Back-to-back frames
        apply_reset();
        for (int c = 0; c < 90; c++) cycle(c < 64);
        check_val("bb_first_ov", first_ov, 16);
        check_val("bb_n_ov", n_ov, 64);
        check_val("bb_n_in_sel", n_in, 32);
        check_val("bb_n_out_sel", n_osel, 32);
        check_val("bb_last", last_ol, 79);
        check_val("bb_n_last", n_last, 2);
        check_val("bb_frame_cnt", frame_cnt, 2);

        // Gap in LOAD, then a fresh frame at 20
        apply_reset();
        for (int c = 0; c < 20; c++) cycle(c < 10);
        check_val("gl_err_cyc", err_cyc, 11);
        check_val("gl_n_ov", n_ov, 0);
        check_val("gl_frame_cnt", frame_cnt, 0);
        for (int c = 20; c < 76; c++) cycle(c < 52);
        check_val("gl_first_ov", first_ov, 36);
        check_val("gl_last", last_ol, 67);
        check_val("gl_frame_cnt2", frame_cnt, 1);

        // Gap in COMPUTE of frame 2
        apply_reset();
        for (int c = 0; c < 61; c++) cycle(c < 50);
        check_val("gc_err_cyc", err_cyc, 51);
        check_val("gc_last", last_ol, 47);
        check_val("gc_n_last", n_last, 1);
        check_val("gc_frame_cnt", frame_cnt, 1);

        // Reset in the drain of a single frame, then a fresh frame
        apply_reset();
        for (int c = 0; c < 40; c++) cycle(c < 32);
        check_val("rm_ov_before", out_valid, 1);
        apply_reset();
        check_val("rm_n_last", n_last, 0);
        check_val("rm_frame_cnt", frame_cnt, 0);
        for (int c = 0; c < 56; c++) cycle(c < 32);
        check_val("rm_first_ov", first_ov, 16);
        check_val("rm_last", last_ol, 47);
        check_val("rm_frame_cnt2", frame_cnt, 1);

        // Frame counter wrap on the CNT_W=2 instance
        apply_reset();
        for (int c = 0; c < 5 * 2 * HALF + 24; c++) cycle(c < 5 * 2 * HALF);
        check_val("wr_frame_cnt_w", w_frame_cnt, 1);
        check_val("wr_frame_cnt", frame_cnt, 5);

        // Randomized streams
        apply_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                apply_reset();
            end else if (r < 5) begin
                int unsigned nf;
                nf = $urandom_range(1, 3);
                repeat (nf * 2 * HALF) cycle(1'b1);
                repeat ($urandom_range(0, 4)) cycle(1'b0);
            end else if (r < 8) begin
                repeat ($urandom_range(1, 2 * HALF - 1)) cycle(1'b1);
                repeat ($urandom_range(1, 6)) cycle(1'b0);
            end else begin
                for (int k = 0; k < 20; k++) cycle($urandom_range(0, 3) != 0);
            end
        end
        repeat (3 * HALF) cycle(1'b0);
        check_val("rnd_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
